// File: rtl/lab7soc_onchip_mem_arbiter_if.sv
// Avalon-MM requester port and single-port on-chip memory port used by the
// two-requester memory arbiter.
interface lab7soc_avmm_if #(
   parameter int ADDR_W = 2
);
   logic [ADDR_W-1:0] address;
   logic [3:0]        byteenable;
   logic              read;
   logic              write;
   logic [31:0]       writedata;
   logic              waitrequest;
   logic [31:0]       readdata;
   logic              readdatavalid;

   modport master (
      output address, byteenable, read, write, writedata,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, byteenable, read, write, writedata,
      output waitrequest, readdata, readdatavalid
   );
endinterface

interface lab7soc_mem_if #(
   parameter int ADDR_W = 2
);
   logic [ADDR_W-1:0] address;
   logic [3:0]        byteenable;
   logic              chipselect;
   logic              write;
   logic [31:0]       writedata;
   logic              clken;
   logic [31:0]       readdata;

   modport master (
      output address, byteenable, chipselect, write, writedata, clken,
      input  readdata
   );

   modport slave (
      input  address, byteenable, chipselect, write, writedata, clken,
      output readdata
   );
endinterface

// File: rtl/lab7soc_onchip_mem_arbiter.sv
// Round-robin arbiter giving the NIOS data master (m0) and the sprite fetch
// engine (m1) shared access to a single-port on-chip memory.
module lab7soc_onchip_mem_arbiter #(
   parameter int ADDR_W       = 2,
   parameter int READ_LATENCY = 1
) (
   input  logic            clk,
   input  logic            reset_n,
   lab7soc_avmm_if.slave   m0,
   lab7soc_avmm_if.slave   m1,
   lab7soc_mem_if.master   mem
);

   logic                    r_last_grant;
   logic [READ_LATENCY-1:0] r_tag_valid;
   logic [READ_LATENCY-1:0] r_tag_owner;

   logic w_req0;
   logic w_req1;
   logic w_grant0;
   logic w_grant1;
   logic w_push;

   assign w_req0 = m0.read | m0.write;
   assign w_req1 = m1.read | m1.write;

   // Ties go to whichever requester was not served last; reset blocks all grants.
   assign w_grant0 = reset_n & w_req0 & (~w_req1 | r_last_grant);
   assign w_grant1 = reset_n & w_req1 & (~w_req0 | ~r_last_grant);

   assign m0.waitrequest = w_req0 & ~w_grant0;
   assign m1.waitrequest = w_req1 & ~w_grant1;

   // A write wins over a simultaneous read, so only pure reads get a tag.
   assign w_push = (w_grant0 & m0.read & ~m0.write) |
                   (w_grant1 & m1.read & ~m1.write);

   assign mem.chipselect = w_grant0 | w_grant1;
   assign mem.clken      = 1'b1;
   assign mem.address    = w_grant1 ? m1.address    : m0.address;
   assign mem.byteenable = w_grant1 ? m1.byteenable : m0.byteenable;
   assign mem.writedata  = w_grant1 ? m1.writedata  : m0.writedata;
   assign mem.write      = (w_grant0 & m0.write) | (w_grant1 & m1.write);

   assign m0.readdata      = mem.readdata;
   assign m1.readdata      = mem.readdata;
   assign m0.readdatavalid = r_tag_valid[READ_LATENCY-1] & ~r_tag_owner[READ_LATENCY-1];
   assign m1.readdatavalid = r_tag_valid[READ_LATENCY-1] &  r_tag_owner[READ_LATENCY-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_last_grant <= 1'b1;
         r_tag_valid  <= '0;
         r_tag_owner  <= '0;
      end else begin
         r_tag_valid[0] <= w_push;
         r_tag_owner[0] <= w_grant1;
         for (int i = 1; i < READ_LATENCY; i++) begin
            r_tag_valid[i] <= r_tag_valid[i-1];
            r_tag_owner[i] <= r_tag_owner[i-1];
         end
         if (w_grant0) begin
            r_last_grant <= 1'b0;
         end else if (w_grant1) begin
            r_last_grant <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_lab7soc_onchip_mem_arbiter.sv
// Directed bench: a READ_LATENCY=1 instance driven from a vector table and a
// READ_LATENCY=2 instance exercised with hand-written alternation/reset sequences.
module tb_lab7soc_onchip_mem_arbiter;

   logic clk = 1'b0;
   logic rst_a = 1'b0;
   logic rst_b = 1'b0;
   int   n_pass = 0;
   int   n_tot  = 0;

   always #5 clk = ~clk;

   lab7soc_avmm_if #(.ADDR_W(2)) a_m0 ();
   lab7soc_avmm_if #(.ADDR_W(2)) a_m1 ();
   lab7soc_mem_if  #(.ADDR_W(2)) a_mem ();
   lab7soc_avmm_if #(.ADDR_W(2)) b_m0 ();
   lab7soc_avmm_if #(.ADDR_W(2)) b_m1 ();
   lab7soc_mem_if  #(.ADDR_W(2)) b_mem ();

   lab7soc_onchip_mem_arbiter #(.ADDR_W(2), .READ_LATENCY(1)) dut_a (
      .clk(clk), .reset_n(rst_a), .m0(a_m0), .m1(a_m1), .mem(a_mem));

   lab7soc_onchip_mem_arbiter #(.ADDR_W(2), .READ_LATENCY(2)) dut_b (
      .clk(clk), .reset_n(rst_b), .m0(b_m0), .m1(b_m1), .mem(b_mem));

   // Memory models: contents reload to 0x1111_000k while reset is held.
   logic [31:0] ram_a [4];
   logic [31:0] ram_b [4];
   logic [31:0] rd_a;
   logic [31:0] rd_b1;
   logic [31:0] rd_b2;

   always @(posedge clk) begin
      if (!rst_a) begin
         for (int k = 0; k < 4; k++) ram_a[k] <= 32'h1111_0000 + 32'(k);
      end else if (a_mem.chipselect) begin
         if (a_mem.write) begin
            for (int k = 0; k < 4; k++)
               if (a_mem.byteenable[k]) ram_a[a_mem.address][8*k +: 8] <= a_mem.writedata[8*k +: 8];
         end else begin
            rd_a <= ram_a[a_mem.address];
         end
      end
   end
   assign a_mem.readdata = rd_a;

   always @(posedge clk) begin
      if (!rst_b) begin
         for (int k = 0; k < 4; k++) ram_b[k] <= 32'h1111_0000 + 32'(k);
      end else if (b_mem.chipselect && !b_mem.write) begin
         rd_b1 <= ram_b[b_mem.address];
      end
      rd_b2 <= rd_b1;
   end
   assign b_mem.readdata = rd_b2;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else n_pass++;
   endtask

   typedef struct {
      logic r0; logic w0; logic [1:0] a0; logic [3:0] be0; logic [31:0] d0;
      logic r1; logic w1; logic [1:0] a1; logic [3:0] be1; logic [31:0] d1;
      logic e_wt0; logic e_wt1; logic e_cs; logic e_mw; logic [1:0] e_ma;
      logic e_v0; logic e_v1; logic [31:0] e_rd;
   } vec_t;

   vec_t vecs [17];

   task automatic apply_a(input vec_t v);
      a_m0.read = v.r0; a_m0.write = v.w0; a_m0.address = v.a0;
      a_m0.byteenable = v.be0; a_m0.writedata = v.d0;
      a_m1.read = v.r1; a_m1.write = v.w1; a_m1.address = v.a1;
      a_m1.byteenable = v.be1; a_m1.writedata = v.d1;
   endtask

   initial begin
      //           r0 w0 a0 be0   d0            r1 w1 a1 be1   d1            wt0 wt1 cs mw ma v0 v1 rd
      vecs[0]  = '{1, 0, 0, 4'hF, 32'h0,        0, 0, 0, 4'hF, 32'h0,        0, 0, 1, 0, 0, 0, 0, 32'h0};
      vecs[1]  = '{0, 1, 2, 4'hF, 32'hDEADBEEF, 0, 0, 0, 4'hF, 32'h0,        0, 0, 1, 1, 2, 1, 0, 32'h1111_0000};
      vecs[2]  = '{1, 0, 2, 4'hF, 32'h0,        0, 0, 0, 4'hF, 32'h0,        0, 0, 1, 0, 2, 0, 0, 32'h0};
      vecs[3]  = '{0, 0, 0, 4'hF, 32'h0,        0, 0, 0, 4'hF, 32'h0,        0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF};
      vecs[4]  = '{1, 0, 2, 4'hF, 32'h0,        1, 0, 3, 4'hF, 32'h0,        1, 0, 1, 0, 3, 0, 0, 32'h0};
      vecs[5]  = '{1, 0, 2, 4'hF, 32'h0,        1, 0, 3, 4'hF, 32'h0,        0, 1, 1, 0, 2, 0, 1, 32'h1111_0003};
      vecs[6]  = '{1, 0, 2, 4'hF, 32'h0,        1, 0, 3, 4'hF, 32'h0,        1, 0, 1, 0, 3, 1, 0, 32'hDEADBEEF};
      vecs[7]  = '{0, 1, 1, 4'hF, 32'h11223344, 0, 0, 0, 4'hF, 32'h0,        0, 0, 1, 1, 1, 0, 1, 32'h1111_0003};
      vecs[8]  = '{0, 0, 0, 4'hF, 32'h0,        0, 1, 1, 4'h5, 32'hAABBCCDD, 0, 0, 1, 1, 1, 0, 0, 32'h0};
      vecs[9]  = '{1, 0, 1, 4'hF, 32'h0,        0, 0, 0, 4'hF, 32'h0,        0, 0, 1, 0, 1, 0, 0, 32'h0};
      vecs[10] = '{0, 0, 0, 4'hF, 32'h0,        1, 0, 3, 4'hF, 32'h0,        0, 0, 1, 0, 3, 1, 0, 32'h11BB33DD};
      vecs[11] = '{0, 1, 0, 4'hF, 32'h5,        1, 0, 0, 4'hF, 32'h0,        0, 1, 1, 1, 0, 0, 1, 32'h1111_0003};
      vecs[12] = '{0, 0, 0, 4'hF, 32'h0,        1, 0, 0, 4'hF, 32'h0,        0, 0, 1, 0, 0, 0, 0, 32'h0};
      vecs[13] = '{0, 0, 0, 4'hF, 32'h0,        0, 0, 0, 4'hF, 32'h0,        0, 0, 0, 0, 0, 0, 1, 32'h5};
      vecs[14] = '{1, 1, 3, 4'hF, 32'h77,       0, 0, 0, 4'hF, 32'h0,        0, 0, 1, 1, 3, 0, 0, 32'h0};
      vecs[15] = '{1, 0, 3, 4'hF, 32'h0,        0, 0, 0, 4'hF, 32'h0,        0, 0, 1, 0, 3, 0, 0, 32'h0};
      vecs[16] = '{0, 0, 0, 4'hF, 32'h0,        0, 0, 0, 4'hF, 32'h0,        0, 0, 0, 0, 0, 1, 0, 32'h77};

      apply_a(vecs[0]);
      b_m0.read = 1'b1; b_m0.write = 1'b0; b_m0.address = 2'd1;
      b_m0.byteenable = 4'hF; b_m0.writedata = 32'h0;
      b_m1.read = 1'b1; b_m1.write = 1'b0; b_m1.address = 2'd2;
      b_m1.byteenable = 4'hF; b_m1.writedata = 32'h0;

      // Reset held with m0 reading: stalled, memory deselected, no strobes.
      repeat (3) @(negedge clk);
      #1;
      chk("rst wt0", 32'(a_m0.waitrequest), 32'd1);
      chk("rst cs", 32'(a_mem.chipselect), 32'd0);
      chk("rst v0", 32'(a_m0.readdatavalid), 32'd0);
      chk("rst v1", 32'(a_m1.readdatavalid), 32'd0);
      chk("clken", 32'(a_mem.clken), 32'd1);

      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         apply_a(vecs[i]);
         if (i == 0) rst_a = 1'b1;
         #1;
         chk($sformatf("row%0d wt0", i), 32'(a_m0.waitrequest), 32'(vecs[i].e_wt0));
         chk($sformatf("row%0d wt1", i), 32'(a_m1.waitrequest), 32'(vecs[i].e_wt1));
         chk($sformatf("row%0d cs", i), 32'(a_mem.chipselect), 32'(vecs[i].e_cs));
         chk($sformatf("row%0d mw", i), 32'(a_mem.write), 32'(vecs[i].e_mw));
         chk($sformatf("row%0d maddr", i), 32'(a_mem.address), 32'(vecs[i].e_ma));
         chk($sformatf("row%0d v0", i), 32'(a_m0.readdatavalid), 32'(vecs[i].e_v0));
         chk($sformatf("row%0d v1", i), 32'(a_m1.readdatavalid), 32'(vecs[i].e_v1));
         if (vecs[i].e_v0) chk($sformatf("row%0d rd0", i), a_m0.readdata, vecs[i].e_rd);
         if (vecs[i].e_v1) chk($sformatf("row%0d rd1", i), a_m1.readdata, vecs[i].e_rd);
      end

      // Latency-2 instance: both reading from reset alternate m0, m1, m0, m1.
      @(negedge clk);
      #1;
      chk("b rst wt0", 32'(b_m0.waitrequest), 32'd1);
      chk("b rst wt1", 32'(b_m1.waitrequest), 32'd1);
      chk("b rst cs", 32'(b_mem.chipselect), 32'd0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 0) rst_b = 1'b1;
         if (k == 4) begin
            b_m0.read = 1'b0;
            b_m1.read = 1'b0;
         end
         #1;
         if (k < 4) begin
            chk($sformatf("alt%0d wt0", k), 32'(b_m0.waitrequest), 32'(k % 2));
            chk($sformatf("alt%0d wt1", k), 32'(b_m1.waitrequest), 32'((k + 1) % 2));
            chk($sformatf("alt%0d maddr", k), 32'(b_mem.address), (k % 2 == 1) ? 32'd2 : 32'd1);
         end
         chk($sformatf("alt%0d v0", k), 32'(b_m0.readdatavalid), 32'(k >= 2 && k % 2 == 0));
         chk($sformatf("alt%0d v1", k), 32'(b_m1.readdatavalid), 32'(k >= 2 && k % 2 == 1));
         if (k >= 2 && k % 2 == 0) chk($sformatf("alt%0d rd0", k), b_m0.readdata, 32'h1111_0001);
         if (k >= 2 && k % 2 == 1) chk($sformatf("alt%0d rd1", k), b_m1.readdata, 32'h1111_0002);
      end

      // Undisturbed m1 read: strobe exactly two cycles after acceptance.
      @(negedge clk);
      b_m1.read = 1'b1; b_m1.address = 2'd3;
      #1 chk("lat2 accept", 32'(b_m1.waitrequest), 32'd0);
      @(negedge clk);
      b_m1.read = 1'b0;
      #1 chk("lat2 +1 v1", 32'(b_m1.readdatavalid), 32'd0);
      @(negedge clk);
      #1 chk("lat2 +2 v1", 32'(b_m1.readdatavalid), 32'd1);
      chk("lat2 +2 rd1", b_m1.readdata, 32'h1111_0003);
      @(negedge clk);
      #1 chk("lat2 +3 v1", 32'(b_m1.readdatavalid), 32'd0);

      // Same read, but reset pulsed while it is in flight: strobe must vanish.
      @(negedge clk);
      b_m1.read = 1'b1; b_m1.address = 2'd0;
      #1 chk("mid accept", 32'(b_m1.waitrequest), 32'd0);
      @(negedge clk);
      b_m1.read = 1'b0;
      rst_b = 1'b0;
      #1 chk("mid in rst v1", 32'(b_m1.readdatavalid), 32'd0);
      #2 rst_b = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1 chk($sformatf("mid +%0d v1", k + 2), 32'(b_m1.readdatavalid), 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
